// File: rtl/sigbuffer_pkg.sv
// rtl/sigbuffer_pkg.sv - shared types for the signal-buffer bank scheduler
package sigbuffer_pkg;

  // Scheduler states: waiting, one-cycle start strobe, read in progress
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } sched_state_e;

  localparam int DEFAULT_BANKS = 2;
  localparam int DEFAULT_BBITS = $clog2(DEFAULT_BANKS);

  // Bank index at the default bank count
  typedef logic [DEFAULT_BBITS-1:0] bank_idx_t;

  // Saturating 16-bit increment used by the optional statistics counters
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/bank_fifo.sv
// rtl/bank_fifo.sv - ring-buffer queue of filled bank indices, oldest first
module bank_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 1,
  localparam int PBITS = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [PBITS:0]   count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PBITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [PBITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [PBITS:0]   count_q, count_d;
  logic             pop_ok;
  logic             push_ok;

  // Next-state for storage, pointers and occupancy; pointers wrap naturally
  // because DEPTH is a power of two
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pop_ok   = pop_i && (count_q != '0);
    push_ok  = push_i && ((count_q != (PBITS+1)'(DEPTH)) || pop_ok);
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + PBITS'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PBITS'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PBITS+1)'(1);
      2'b01:   count_d = count_q - (PBITS+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/bank_scheduler.sv
// rtl/bank_scheduler.sv - schedules reads of filled signal-buffer banks; optional BANK_SCHEDULER_STATS_EN counters
module bank_scheduler
  import sigbuffer_pkg::*;
#(
  parameter  int BANKS = DEFAULT_BANKS,
  localparam int BBITS = $clog2(BANKS)
) (
  input  logic             vis_clk,
  input  logic             vis_rst,
  input  logic             enable_i,
  input  logic             fill_i,
  input  logic [BBITS-1:0] fill_bank_i,
  input  logic             done_i,
  input  logic             clear_i,
  output logic             start_o,
  output logic [BBITS-1:0] rbank_o,
  output logic             busy_o,
  output logic [BBITS:0]   pending_o,
  output logic             overflow_o
`ifdef BANK_SCHEDULER_STATS_EN
  ,
  output logic [15:0]      served_o,
  output logic [15:0]      dropped_o
`endif
);

  sched_state_e     state_q, state_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic [BBITS-1:0] rbank_q, rbank_d;
  logic             done_q, done_d;
  logic             overflow_q, overflow_d;

  logic             pop;
  logic             push;
  logic             fill_drop;
  logic             fill_hit;
  logic             ovf_evt;
  logic [BBITS-1:0] head;
  logic [BBITS:0]   count;

  bank_fifo #(
    .DEPTH (BANKS),
    .WIDTH (BBITS)
  ) u_fifo (
    .clk         (vis_clk),
    .rst         (vis_rst),
    .push_i      (push),
    .push_data_i (fill_bank_i),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count)
  );

  // Fill handling: drop when full with no same-cycle pop, flag writer/reader collisions
  always_comb begin
    fill_drop = fill_i && (count == (BBITS+1)'(BANKS)) && !pop;
    fill_hit  = fill_i && busy_q && (fill_bank_i == rbank_q);
    push      = fill_i && !fill_drop;
    ovf_evt   = fill_drop || fill_hit;
    if (ovf_evt) begin
      overflow_d = 1'b1;
    end else if (clear_i) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Scheduler next-state; done is registered so the next start lands two
  // cycles after the reader's done pulse, and done outside RUN is discarded
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    busy_d  = busy_q;
    rbank_d = rbank_q;
    pop     = 1'b0;
    done_d  = done_i && (state_q == RUN);
    case (state_q)
      IDLE: begin
        if (enable_i && (count != '0)) begin
          pop     = 1'b1;
          rbank_d = head;
          start_d = 1'b1;
          busy_d  = 1'b1;
          state_d = ARM;
        end
      end
      ARM: begin
        state_d = RUN;
      end
      RUN: begin
        if (done_q) begin
          if (enable_i && (count != '0)) begin
            pop     = 1'b1;
            rbank_d = head;
            start_d = 1'b1;
            state_d = ARM;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Scheduler state and registered outputs
  always_ff @(posedge vis_clk or posedge vis_rst) begin
    if (vis_rst) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      rbank_q    <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      rbank_q    <= rbank_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  assign start_o    = start_q;
  assign rbank_o    = rbank_q;
  assign busy_o     = busy_q;
  assign pending_o  = count;
  assign overflow_o = overflow_q;

`ifdef BANK_SCHEDULER_STATS_EN
  logic [15:0] served_q, served_d;
  logic [15:0] dropped_q, dropped_d;

  // Saturating transaction and lost/collided-fill counters
  always_comb begin
    served_d  = served_q;
    dropped_d = dropped_q;
    if (clear_i) begin
      served_d  = '0;
      dropped_d = '0;
    end else begin
      if (start_q) served_d  = sat_inc16(served_q);
      if (ovf_evt) dropped_d = sat_inc16(dropped_q);
    end
  end

  // Statistics registers
  always_ff @(posedge vis_clk or posedge vis_rst) begin
    if (vis_rst) begin
      served_q  <= '0;
      dropped_q <= '0;
    end else begin
      served_q  <= served_d;
      dropped_q <= dropped_d;
    end
  end

  assign served_o  = served_q;
  assign dropped_o = dropped_q;
`endif

endmodule

// File: tb/tb_bank_scheduler.sv
// tb/tb_bank_scheduler.sv - directed self-checking bench for bank_scheduler at BANKS=2
module tb_bank_scheduler;

  logic       vis_clk = 1'b0;
  logic       vis_rst;
  logic       enable_i;
  logic       fill_i;
  logic [0:0] fill_bank_i;
  logic       done_i;
  logic       clear_i;
  logic       start_o;
  logic [0:0] rbank_o;
  logic       busy_o;
  logic [1:0] pending_o;
  logic       overflow_o;
`ifdef BANK_SCHEDULER_STATS_EN
  logic [15:0] served_o;
  logic [15:0] dropped_o;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 vis_clk = ~vis_clk;

  bank_scheduler #(.BANKS(2)) dut (
    .vis_clk     (vis_clk),
    .vis_rst     (vis_rst),
    .enable_i    (enable_i),
    .fill_i      (fill_i),
    .fill_bank_i (fill_bank_i),
    .done_i      (done_i),
    .clear_i     (clear_i),
    .start_o     (start_o),
    .rbank_o     (rbank_o),
    .busy_o      (busy_o),
    .pending_o   (pending_o),
    .overflow_o  (overflow_o)
`ifdef BANK_SCHEDULER_STATS_EN
    ,
    .served_o    (served_o),
    .dropped_o   (dropped_o)
`endif
  );

  task automatic step();
    @(posedge vis_clk);
    #1;
  endtask

  task automatic test_reset();
    vis_rst = 1'b1; enable_i = 1'b0; fill_i = 1'b0; fill_bank_i = 1'b0;
    done_i = 1'b0; clear_i = 1'b0;
    step(); step();
    tests_run++; if (start_o !== 1'b0) begin tests_failed++; $display("FAIL reset_start: got %0b expected 0", start_o); end
    tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b expected 0", busy_o); end
    tests_run++; if (rbank_o !== 1'b0) begin tests_failed++; $display("FAIL reset_rbank: got %0d expected 0", rbank_o); end
    tests_run++; if (pending_o !== 2'd0) begin tests_failed++; $display("FAIL reset_pending: got %0d expected 0", pending_o); end
    tests_run++; if (overflow_o !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %0b expected 0", overflow_o); end
    vis_rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    enable_i = 1'b1;
    fill_i = 1'b1; fill_bank_i = 1'b1; step(); fill_i = 1'b0;
    tests_run++; if (pending_o !== 2'd1) begin tests_failed++; $display("FAIL single_pending1: got %0d expected 1", pending_o); end
    tests_run++; if (start_o !== 1'b0) begin tests_failed++; $display("FAIL single_early_start: got %0b expected 0", start_o); end
    step();
    tests_run++; if (start_o !== 1'b1) begin tests_failed++; $display("FAIL single_start: got %0b expected 1", start_o); end
    tests_run++; if (rbank_o !== 1'b1) begin tests_failed++; $display("FAIL single_rbank: got %0d expected 1", rbank_o); end
    tests_run++; if (busy_o !== 1'b1) begin tests_failed++; $display("FAIL single_busy: got %0b expected 1", busy_o); end
    tests_run++; if (pending_o !== 2'd0) begin tests_failed++; $display("FAIL single_pending0: got %0d expected 0", pending_o); end
    step();
    tests_run++; if (start_o !== 1'b0) begin tests_failed++; $display("FAIL single_start_pulse: got %0b expected 0", start_o); end
    done_i = 1'b1; step(); done_i = 1'b0; step();
    tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL single_idle: got %0b expected 0", busy_o); end
  endtask

  task automatic test_back_to_back();
    fill_i = 1'b1; fill_bank_i = 1'b1; step(); fill_i = 1'b0;
    step(); step();
    fill_i = 1'b1; fill_bank_i = 1'b0; step();
    fill_bank_i = 1'b1; step(); fill_i = 1'b0;
    tests_run++; if (pending_o !== 2'd2) begin tests_failed++; $display("FAIL b2b_pending2: got %0d expected 2", pending_o); end
    tests_run++; if (overflow_o !== 1'b1) begin tests_failed++; $display("FAIL b2b_collision: got %0b expected 1", overflow_o); end
    clear_i = 1'b1; step(); clear_i = 1'b0;
    tests_run++; if (overflow_o !== 1'b0) begin tests_failed++; $display("FAIL b2b_clear: got %0b expected 0", overflow_o); end
    done_i = 1'b1; step(); done_i = 1'b0;
    tests_run++; if (start_o !== 1'b0) begin tests_failed++; $display("FAIL b2b_start_1cyc: got %0b expected 0", start_o); end
    step();
    tests_run++; if (start_o !== 1'b1) begin tests_failed++; $display("FAIL b2b_start_2cyc: got %0b expected 1", start_o); end
    tests_run++; if (rbank_o !== 1'b0) begin tests_failed++; $display("FAIL b2b_rbank0: got %0d expected 0", rbank_o); end
    tests_run++; if (pending_o !== 2'd1) begin tests_failed++; $display("FAIL b2b_pending1: got %0d expected 1", pending_o); end
    step();
    done_i = 1'b1; step(); done_i = 1'b0; step();
    tests_run++; if (start_o !== 1'b1) begin tests_failed++; $display("FAIL b2b_second_start: got %0b expected 1", start_o); end
    tests_run++; if (rbank_o !== 1'b1) begin tests_failed++; $display("FAIL b2b_rbank1: got %0d expected 1", rbank_o); end
    step();
    done_i = 1'b1; step(); done_i = 1'b0; step();
    tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle: got %0b expected 0", busy_o); end
  endtask

  task automatic test_overflow();
    enable_i = 1'b0;
    fill_i = 1'b1; fill_bank_i = 1'b0; step();
    fill_bank_i = 1'b1; step();
    fill_bank_i = 1'b0; step(); fill_i = 1'b0;
    tests_run++; if (pending_o !== 2'd2) begin tests_failed++; $display("FAIL ovf_pending: got %0d expected 2", pending_o); end
    tests_run++; if (overflow_o !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag: got %0b expected 1", overflow_o); end
    clear_i = 1'b1; step(); clear_i = 1'b0;
    tests_run++; if (overflow_o !== 1'b0) begin tests_failed++; $display("FAIL ovf_clear: got %0b expected 0", overflow_o); end
    clear_i = 1'b1; fill_i = 1'b1; fill_bank_i = 1'b1; step(); fill_i = 1'b0;
    tests_run++; if (overflow_o !== 1'b1) begin tests_failed++; $display("FAIL ovf_priority: got %0b expected 1", overflow_o); end
    step(); clear_i = 1'b0;
    enable_i = 1'b1; step();
    tests_run++; if (rbank_o !== 1'b0) begin tests_failed++; $display("FAIL ovf_order_first: got %0d expected 0", rbank_o); end
    tests_run++; if (pending_o !== 2'd1) begin tests_failed++; $display("FAIL ovf_drain1: got %0d expected 1", pending_o); end
    step();
    done_i = 1'b1; step(); done_i = 1'b0; step();
    tests_run++; if (rbank_o !== 1'b1) begin tests_failed++; $display("FAIL ovf_order_second: got %0d expected 1", rbank_o); end
    step();
    done_i = 1'b1; step(); done_i = 1'b0; step();
  endtask

  task automatic test_collision_and_reset();
    fill_i = 1'b1; fill_bank_i = 1'b0; step(); fill_i = 1'b0;
    step();
    tests_run++; if (start_o !== 1'b1) begin tests_failed++; $display("FAIL coll_start: got %0b expected 1", start_o); end
    done_i = 1'b1; step(); done_i = 1'b0;
    step();
    tests_run++; if (busy_o !== 1'b1) begin tests_failed++; $display("FAIL done_in_arm_ignored: got %0b expected 1", busy_o); end
    fill_i = 1'b1; fill_bank_i = 1'b0; step(); fill_i = 1'b0;
    tests_run++; if (overflow_o !== 1'b1) begin tests_failed++; $display("FAIL coll_flag: got %0b expected 1", overflow_o); end
    tests_run++; if (pending_o !== 2'd1) begin tests_failed++; $display("FAIL coll_queued: got %0d expected 1", pending_o); end
    vis_rst = 1'b1; #1;
    tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL arst_busy: got %0b expected 0", busy_o); end
    tests_run++; if (pending_o !== 2'd0) begin tests_failed++; $display("FAIL arst_pending: got %0d expected 0", pending_o); end
    tests_run++; if (overflow_o !== 1'b0) begin tests_failed++; $display("FAIL arst_overflow: got %0b expected 0", overflow_o); end
    tests_run++; if (start_o !== 1'b0) begin tests_failed++; $display("FAIL arst_start: got %0b expected 0", start_o); end
    step(); vis_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++; if (start_o !== 1'b0 || busy_o !== 1'b0) begin tests_failed++; $display("FAIL post_reset_idle: got start=%0b busy=%0b expected 0 0", start_o, busy_o); end
    end
    fill_i = 1'b1; fill_bank_i = 1'b1; step(); fill_i = 1'b0; step();
    tests_run++; if (start_o !== 1'b1 || rbank_o !== 1'b1) begin tests_failed++; $display("FAIL post_reset_start: got start=%0b rbank=%0d expected 1 1", start_o, rbank_o); end
    enable_i = 1'b0; step(); step();
    tests_run++; if (busy_o !== 1'b1) begin tests_failed++; $display("FAIL enable_no_abort: got %0b expected 1", busy_o); end
    done_i = 1'b1; step(); done_i = 1'b0; step();
    tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL enable_low_end: got %0b expected 0", busy_o); end
  endtask

`ifdef BANK_SCHEDULER_STATS_EN
  task automatic test_stats();
    vis_rst = 1'b1; step(); vis_rst = 1'b0;
    enable_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      fill_i = 1'b1; fill_bank_i = 1'(i & 1); step(); fill_i = 1'b0;
      step(); step();
      done_i = 1'b1; step(); done_i = 1'b0; step();
    end
    enable_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fill_i = 1'b1; fill_bank_i = 1'(i & 1); step();
    end
    fill_i = 1'b0; step();
    tests_run++; if (served_o !== 16'd5) begin tests_failed++; $display("FAIL stats_served: got %0d expected 5", served_o); end
    tests_run++; if (dropped_o !== 16'd2) begin tests_failed++; $display("FAIL stats_dropped: got %0d expected 2", dropped_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_collision_and_reset();
`ifdef BANK_SCHEDULER_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bank_scheduler.md
BANK_SCHEDULER -- requirements
Module: bank_scheduler

Interface
REQ-001 Parameter BANKS, default 2, number of signal-buffer banks; SHALL be a power of two, at least 2.
REQ-002 Parameter BBITS, default $clog2(BANKS), local, bank-index width.
REQ-003 vis_clk  input  1  correlator clock; the only clock.
REQ-004 vis_rst  input  1  reset, asynchronous and active-high.
REQ-005 enable_i  input  1  permits new transactions to start.
REQ-006 fill_i  input  1  single-cycle pulse: one bank has been completely written (already in vis_clk domain).
REQ-007 fill_bank_i  input  BBITS  index of the bank that was filled; qualified by fill_i.
REQ-008 done_i  input  1  single-cycle pulse from the reader: current transaction finished (last sample of last timeslice).
REQ-009 clear_i  input  1  clears overflow_o.
REQ-010 start_o  output  1  single-cycle pulse that begins a read transaction.
REQ-011 rbank_o  output  BBITS  bank to read; held stable from start_o until done_i.
REQ-012 busy_o  output  1  transaction in progress.
REQ-013 pending_o  output  BBITS+1  number of filled banks awaiting reading.
REQ-014 overflow_o  output  1  sticky flag: fill lost or bank collision.

Function
REQ-015 Filled bank indices SHALL be queued in a FIFO of depth BANKS, oldest first.
REQ-016 The FSM SHALL have the states IDLE, ARM and RUN.
REQ-017 IDLE->ARM when enable_i=1 and pending_o>0; rbank_o SHALL be loaded from the FIFO head and the entry popped on that edge.
REQ-018 ARM SHALL last exactly one cycle with start_o=1, then go to RUN.
REQ-019 busy_o SHALL be 1 in ARM and RUN.
REQ-020 In RUN, done_i with enable_i=1 and pending_o>0 SHALL go to ARM and pop the next bank (back-to-back, 2 cycles from done_i to start_o); otherwise RUN->IDLE.
REQ-021 done_i in IDLE or ARM SHALL be ignored.
REQ-022 Deasserting enable_i SHALL NOT abort RUN; it only blocks the next start.
REQ-023 fill_i with pending_o<BANKS SHALL push fill_bank_i; pending_o updates on the next cycle.
REQ-024 fill_i and a pop in the same cycle SHALL both take effect; pending_o unchanged.
REQ-025 fill_i with pending_o==BANKS and no same-cycle pop SHALL drop the entry and set overflow_o.
REQ-026 fill_i with busy_o=1 and fill_bank_i==rbank_o (writer overran reader) SHALL still be queued and SHALL set overflow_o.
REQ-027 clear_i SHALL clear overflow_o; a simultaneous overflow event SHALL take priority (flag stays 1).
REQ-028 FIFO pointers SHALL wrap modulo BANKS; pending_o SHALL never exceed BANKS.

Reset
REQ-029 vis_rst SHALL asynchronously force IDLE, an empty FIFO, start_o=0, busy_o=0, rbank_o=0, pending_o=0, overflow_o=0.
REQ-030 Reset asserted mid-transaction SHALL discard all queued banks; operation resumes only on fills received after release.

Configuration
REQ-031 Macro BANK_SCHEDULER_STATS_EN: when defined, adds outputs served_o[15:0] (incremented at each start_o) and dropped_o[15:0] (incremented at each REQ-025/REQ-026 event), both saturating at 16'hFFFF and cleared by vis_rst and clear_i; when undefined, these ports and counters SHALL be absent and behaviour is otherwise identical.

Structure
REQ-032 The shared package sigbuffer_pkg SHALL hold the FSM state enum (IDLE, ARM, RUN) and the bank-index width typedef.
REQ-033 The FIFO SHALL be a sub-module bank_fifo (depth BANKS, width BBITS, push/pop/count ports); the FSM and flags stay in bank_scheduler.

Verification
REQ-034 Reset, enable_i=1, fill_i with bank 1 -> pending_o=1, then start_o one cycle later with rbank_o=1, busy_o=1, pending_o=0.
REQ-035 BANKS=2: fills of banks 0 and 1 during RUN, then done_i -> start_o exactly 2 cycles after done_i, rbank_o=0, then bank 1 after the next done_i.
REQ-036 BANKS=2, enable_i=0: three fills -> pending_o=2, overflow_o=1; clear_i -> overflow_o=0.
REQ-037 RUN on bank 0, fill_i with bank 0 -> overflow_o=1, entry queued, pending_o=1.
REQ-038 vis_rst pulsed in RUN with pending_o=1 -> all outputs 0 immediately; no start_o after release until a new fill_i.
REQ-039 With BANK_SCHEDULER_STATS_EN: 5 transactions and 2 drops -> served_o=5, dropped_o=2.
